// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS32 field layout, formats and opcode constants
//
// Purpose: common definitions for the MIPS32 instruction encoder and decoder.
//   fmt_t          : bundle format code (R, I, J, illegal)
//   *_MSB / *_LSB  : bit positions of each field inside a 32-bit instruction
//   OP_*           : opcodes that decide format legality
package mips_pkg;

  typedef enum logic [1:0] {
    FMT_R   = 2'd0,
    FMT_I   = 2'd1,
    FMT_J   = 2'd2,
    FMT_BAD = 2'd3
  } fmt_t;

  localparam int INSTR_W    = 32;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_MSB  = 10;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;
  localparam int ADDR_MSB   = 25;
  localparam int ADDR_LSB   = 0;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;

endpackage

// File: rtl/skid_buf.sv
// rtl/skid_buf.sv - two-entry skid buffer with a registered input ready
//
// Purpose: decouples a producer from a consumer at full throughput while
//   keeping in_ready a flop output. Data leaves from the main register; the
//   skid register catches the one word that can arrive in the cycle the
//   consumer stalls.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   clear                : synchronous flush of both entries (wins over transfers)
//   in_valid / in_ready  : producer handshake (in_ready is registered)
//   in_data              : producer payload
//   out_valid / out_ready: consumer handshake
//   out_data             : consumer payload, held stable while stalled
module skid_buf #(
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  logic              main_valid, main_valid_nx;
  logic              skid_valid, skid_valid_nx;
  logic [DATA_W-1:0] main_data, main_data_nx;
  logic [DATA_W-1:0] skid_data, skid_data_nx;
  logic              ready_q;
  logic              in_xfer, out_xfer;

  assign in_xfer  = in_valid && ready_q && !clear;
  assign out_xfer = main_valid && out_ready && !clear;

  // ready_q is kept equal to "skid empty", so a word can only arrive while
  // the skid register is free; the both-full branch never sees in_xfer.
  always_comb begin
    main_valid_nx = main_valid;
    skid_valid_nx = skid_valid;
    main_data_nx  = main_data;
    skid_data_nx  = skid_data;
    if (clear) begin
      main_valid_nx = 1'b0;
      skid_valid_nx = 1'b0;
    end else if (skid_valid) begin
      if (out_xfer) begin
        main_data_nx  = skid_data;
        skid_valid_nx = 1'b0;
      end
    end else if (main_valid) begin
      if (out_xfer && in_xfer) begin
        main_data_nx = in_data;
      end else if (out_xfer) begin
        main_valid_nx = 1'b0;
      end else if (in_xfer) begin
        skid_data_nx  = in_data;
        skid_valid_nx = 1'b1;
      end
    end else if (in_xfer) begin
      main_data_nx  = in_data;
      main_valid_nx = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= RESET_VAL;
      skid_data  <= RESET_VAL;
      ready_q    <= 1'b0;
    end else begin
      main_valid <= main_valid_nx;
      skid_valid <= skid_valid_nx;
      main_data  <= main_data_nx;
      skid_data  <= skid_data_nx;
      ready_q    <= !skid_valid_nx;
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = main_valid;
  assign out_data  = main_data;

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - streaming MIPS32 field-bundle to instruction-word encoder
//
// Purpose: packs decoded field bundles into 32-bit MIPS32 words, rejects
//   illegal format/opcode combinations with a one-cycle err pulse, and tags
//   every emitted word with a sequential word address.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   clear                 : synchronous flush; counter reloads BASE_ADDR
//   in_valid / in_ready   : bundle handshake (in_ready is registered)
//   in_fmt, in_opcode, in_funct, in_rs, in_rt, in_rd, in_shamt, in_imm,
//   in_addr               : decoded fields
//   out_valid / out_ready : word handshake
//   out_instr, out_waddr  : encoded word and its address
//   err                   : pulses the cycle after an illegal bundle is taken
module instr_encoder #(
  parameter int                ADDR_W    = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_fmt,
  input  logic [5:0]        in_opcode,
  input  logic [5:0]        in_funct,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_waddr,
  output logic              err
);

  import mips_pkg::*;

  localparam int BUF_W = INSTR_W + ADDR_W;

  fmt_t               fmt;
  logic [INSTR_W-1:0] word;
  logic               legal;
  logic               accept;
  logic               buf_in_valid;
  logic               buf_in_ready;
  logic [BUF_W-1:0]   buf_out_data;
  logic [ADDR_W-1:0]  waddr_q;
  logic               err_q;

  assign fmt = fmt_t'(in_fmt);

  // Packer and legality check. Fields a format does not use never reach
  // the word, so garbage on them is harmless.
  always_comb begin
    word  = '0;
    legal = 1'b0;
    case (fmt)
      FMT_R: begin
        word[OPCODE_MSB:OPCODE_LSB] = in_opcode;
        word[RS_MSB:RS_LSB]         = in_rs;
        word[RT_MSB:RT_LSB]         = in_rt;
        word[RD_MSB:RD_LSB]         = in_rd;
        word[SHAMT_MSB:SHAMT_LSB]   = in_shamt;
        word[FUNCT_MSB:FUNCT_LSB]   = in_funct;
        legal = (in_opcode == OP_RTYPE);
      end
      FMT_I: begin
        word[OPCODE_MSB:OPCODE_LSB] = in_opcode;
        word[RS_MSB:RS_LSB]         = in_rs;
        word[RT_MSB:RT_LSB]         = in_rt;
        word[IMM_MSB:IMM_LSB]       = in_imm;
        // Opcodes owned by the R and J formats cannot be I-type.
        legal = !(in_opcode inside {OP_RTYPE, OP_J, OP_JAL});
      end
      FMT_J: begin
        word[OPCODE_MSB:OPCODE_LSB] = in_opcode;
        word[ADDR_MSB:ADDR_LSB]     = in_addr;
        legal = (in_opcode == OP_J) || (in_opcode == OP_JAL);
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

  // A bundle is consumed whether legal or not; only legal ones enter the
  // buffer, so an illegal bundle never occupies an entry.
  assign accept       = in_valid && buf_in_ready && !clear;
  assign buf_in_valid = in_valid && legal;
  assign in_ready     = buf_in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waddr_q <= BASE_ADDR;
      err_q   <= 1'b0;
    end else if (clear) begin
      waddr_q <= BASE_ADDR;
      err_q   <= 1'b0;
    end else begin
      if (accept && legal) begin
        waddr_q <= waddr_q + ADDR_W'(1);
      end
      err_q <= accept && !legal;
    end
  end

  skid_buf #(
    .DATA_W    (BUF_W),
    .RESET_VAL ({{INSTR_W{1'b0}}, BASE_ADDR})
  ) u_skid_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (buf_in_valid),
    .in_ready  (buf_in_ready),
    .in_data   ({word, waddr_q}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (buf_out_data)
  );

  assign out_instr = buf_out_data[BUF_W-1:ADDR_W];
  assign out_waddr = buf_out_data[ADDR_W-1:0];
  assign err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - scoreboard bench for instr_encoder
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic [1:0]  in_fmt;
  logic [5:0]  in_opcode;
  logic [5:0]  in_funct;
  logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
  logic [15:0] in_imm;
  logic [25:0] in_addr;
  logic        out_ready;

  logic        in_ready, out_valid, err;
  logic [31:0] out_instr;
  logic [9:0]  out_waddr;
  logic        in_ready_n, out_valid_n, err_n;
  logic [31:0] out_instr_n;
  logic [1:0]  out_waddr_n;

  always #5 clk = ~clk;

  instr_encoder dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_funct(in_funct),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_imm(in_imm), .in_addr(in_addr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_waddr(out_waddr), .err(err)
  );

  instr_encoder #(.ADDR_W(2)) dut_n (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready_n),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_funct(in_funct),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_imm(in_imm), .in_addr(in_addr),
    .out_valid(out_valid_n), .out_ready(out_ready),
    .out_instr(out_instr_n), .out_waddr(out_waddr_n), .err(err_n)
  );

  typedef struct {
    logic [31:0] instr;
    int unsigned addr;
  } exp_t;

  exp_t        q[$];
  logic [9:0]  w_log[$];
  logic [1:0]  n_log[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          err_seen = 0;
  int unsigned exp_addr = 0;
  logic        err_pend = 1'b0;
  logic        mon_en = 1'b0;
  logic        exp_ov, exp_ir;
  logic [32:0] mw;
  exp_t        hd;
  logic        rnd_done;

  function automatic logic [32:0] model_word(input logic [1:0] f, input logic [5:0] op,
      input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
      input logic [5:0] fn, input logic [15:0] imm, input logic [25:0] ad);
    logic        ok;
    logic [31:0] w;
    ok = 1'b0;
    w  = 32'h0;
    case (f)
      2'd0: begin w = {op, rs, rt, rd, sh, fn}; ok = (op == 6'd0); end
      2'd1: begin w = {op, rs, rt, imm}; ok = (op != 6'd0) && (op != 6'd2) && (op != 6'd3); end
      2'd2: begin w = {op, ad}; ok = (op == 6'd2) || (op == 6'd3); end
      default: ok = 1'b0;
    endcase
    return {ok, w};
  endfunction

  // Scoreboard: at each falling edge compare DUT outputs against the model,
  // then apply the transfers that the coming rising edge will perform.
  always @(negedge clk) begin
    if (mon_en) begin
      n_checks++;
      if (err !== err_pend || err_n !== err_pend) begin
        n_fail++;
        $display("FAIL err_pulse: got %b/%b expected %b at %0t", err, err_n, err_pend, $time);
      end
      if (err) err_seen++;
      exp_ov = (q.size() > 0);
      exp_ir = (q.size() < 2);
      n_checks++;
      if (out_valid !== exp_ov || out_valid_n !== exp_ov) begin
        n_fail++;
        $display("FAIL out_valid: got %b/%b expected %b at %0t", out_valid, out_valid_n, exp_ov, $time);
      end
      n_checks++;
      if (in_ready !== exp_ir || in_ready_n !== exp_ir) begin
        n_fail++;
        $display("FAIL in_ready: got %b/%b expected %b at %0t", in_ready, in_ready_n, exp_ir, $time);
      end
      if (exp_ov && out_valid) begin
        hd = q[0];
        n_checks++;
        if (out_instr !== hd.instr || out_instr_n !== hd.instr) begin
          n_fail++;
          $display("FAIL out_instr: got %h/%h expected %h at %0t", out_instr, out_instr_n, hd.instr, $time);
        end
        n_checks++;
        if (out_waddr !== hd.addr[9:0] || out_waddr_n !== hd.addr[1:0]) begin
          n_fail++;
          $display("FAIL out_waddr: got %0d/%0d expected %0d/%0d at %0t", out_waddr, out_waddr_n,
                   hd.addr[9:0], hd.addr[1:0], $time);
        end
      end
      if (clear) begin
        q.delete();
        exp_addr = 0;
        err_pend = 1'b0;
      end else begin
        err_pend = 1'b0;
        if (exp_ov && out_ready) begin
          w_log.push_back(out_waddr);
          n_log.push_back(out_waddr_n);
          void'(q.pop_front());
        end
        if (in_valid && exp_ir) begin
          mw = model_word(in_fmt, in_opcode, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm, in_addr);
          if (mw[32]) begin
            q.push_back('{mw[31:0], exp_addr});
            exp_addr++;
          end else begin
            err_pend = 1'b1;
          end
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [1:0] f, input logic [5:0] op, input logic [4:0] rs,
      input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
      input logic [15:0] imm, input logic [25:0] ad);
    int n;
    in_fmt = f; in_opcode = op; in_rs = rs; in_rt = rt; in_rd = rd;
    in_shamt = sh; in_funct = fn; in_imm = imm; in_addr = ad;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n >= 50) begin
      n_fail++;
      $display("FAIL send_timeout: in_ready stayed %b, required 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_random();
    logic [1:0] f;
    logic [5:0] op;
    f = 2'($urandom_range(0, 3));
    case (f)
      2'd0:    op = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
      2'd2:    op = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'($urandom_range(2, 3));
      default: op = 6'($urandom);
    endcase
    send(f, op, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom),
         16'($urandom), 26'($urandom));
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d words still expected, required 0", q.size());
    end
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_instr !== 32'h0 || out_waddr !== 10'd0 ||
        err !== 1'b0 || in_ready_n !== 1'b0 || out_valid_n !== 1'b0 || out_waddr_n !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_values: in_ready=%b out_valid=%b instr=%h waddr=%0d err=%b, required 0/0/0/0/0",
               in_ready, out_valid, out_instr, out_waddr, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_r_type();
    out_ready = 1'b1;
    send(2'd0, 6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'hFFFF, 26'h3FFFFFF);
    n_checks++;
    if (out_valid !== 1'b1 || out_instr !== 32'h00221820 || out_waddr !== 10'd0) begin
      n_fail++;
      $display("FAIL r_add: valid=%b instr=%h waddr=%0d, required 1 00221820 0", out_valid, out_instr, out_waddr);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    send(2'd1, 6'h08, 5'd1, 5'd2, 5'd31, 5'd31, 6'h3F, 16'h0005, 26'h0);
    n_checks++;
    if (out_valid !== 1'b1 || out_instr !== 32'h20220005 || out_waddr !== 10'd1) begin
      n_fail++;
      $display("FAIL b2b_addi: valid=%b instr=%h waddr=%0d, required 1 20220005 1", out_valid, out_instr, out_waddr);
    end
    send(2'd2, 6'd3, 5'd7, 5'd7, 5'd7, 5'd7, 6'h7, 16'h7, 26'h0000003);
    n_checks++;
    if (out_valid !== 1'b1 || out_instr !== 32'h0C000003 || out_waddr !== 10'd2) begin
      n_fail++;
      $display("FAIL b2b_jal: valid=%b instr=%h waddr=%0d, required 1 0C000003 2", out_valid, out_instr, out_waddr);
    end
    wait_drain();
  endtask

  task automatic test_stall();
    do_clear();
    out_ready = 1'b0;
    w_log.delete();
    send(2'd0, 6'd0, 5'd1, 5'd1, 5'd1, 5'd0, 6'h20, 16'h0, 26'h0);
    send(2'd0, 6'd0, 5'd2, 5'd2, 5'd2, 5'd0, 6'h21, 16'h0, 26'h0);
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_ready: in_ready=%b after two words, required 0", in_ready);
    end
    fork
      send(2'd1, 6'h0D, 5'd3, 5'd3, 5'd0, 5'd0, 6'h0, 16'h1234, 26'h0);
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    send(2'd2, 6'd2, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0ABCDEF);
    wait_drain();
    n_checks++;
    if (w_log.size() != 4 || w_log[0] !== 10'd0 || w_log[1] !== 10'd1 || w_log[2] !== 10'd2 || w_log[3] !== 10'd3) begin
      n_fail++;
      $display("FAIL stall_order: %0d words emitted, required 4 with addresses 0..3", w_log.size());
    end
  endtask

  task automatic test_illegal();
    int base;
    do_clear();
    out_ready = 1'b1;
    base = err_seen;
    send(2'd3, 6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0);
    send(2'd0, 6'h08, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0);
    send(2'd2, 6'h04, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h1);
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (err_seen - base != 3 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_err: %0d err pulses, out_valid=%b, required 3 and 0", err_seen - base, out_valid);
    end
    send(2'd1, 6'h23, 5'd4, 5'd5, 5'd0, 5'd0, 6'h0, 16'h0010, 26'h0);
    n_checks++;
    if (out_valid !== 1'b1 || out_instr !== 32'h8C850010 || out_waddr !== 10'd0) begin
      n_fail++;
      $display("FAIL illegal_next: valid=%b instr=%h waddr=%0d, required 1 8C850010 0", out_valid, out_instr, out_waddr);
    end
    wait_drain();
  endtask

  task automatic test_wrap();
    logic [1:0] exp_wrap [5];
    exp_wrap = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_clear();
    out_ready = 1'b1;
    n_log.delete();
    for (int i = 0; i < 5; i++) begin
      send(2'd0, 6'd0, 5'd1, 5'd2, 5'(i), 5'd0, 6'h20, 16'h0, 26'h0);
    end
    wait_drain();
    n_checks++;
    if (n_log.size() != 5) begin
      n_fail++;
      $display("FAIL wrap_count: %0d words, required 5", n_log.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (n_log[i] !== exp_wrap[i]) begin
          n_fail++;
          $display("FAIL wrap_addr[%0d]: got %0d, required %0d", i, n_log[i], exp_wrap[i]);
        end
      end
    end
  endtask

  task automatic test_clear();
    out_ready = 1'b0;
    do_clear();
    send(2'd0, 6'd0, 5'd1, 5'd1, 5'd1, 5'd0, 6'h20, 16'h0, 26'h0);
    send(2'd0, 6'd0, 5'd2, 5'd2, 5'd2, 5'd0, 6'h20, 16'h0, 26'h0);
    in_fmt = 2'd0; in_opcode = 6'd0; in_funct = 6'h24;
    in_valid = 1'b1;
    do_clear();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_full: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
    end
    send(2'd0, 6'd0, 5'd3, 5'd3, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0);
    in_valid = 1'b1;
    do_clear();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_one: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
    end
    out_ready = 1'b1;
    send(2'd2, 6'd2, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0000100);
    n_checks++;
    if (out_valid !== 1'b1 || out_instr !== 32'h08000100 || out_waddr !== 10'd0) begin
      n_fail++;
      $display("FAIL clear_next: valid=%b instr=%h waddr=%0d, required 1 08000100 0", out_valid, out_instr, out_waddr);
    end
    wait_drain();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send(2'd0, 6'd0, 5'd1, 5'd1, 5'd1, 5'd0, 6'h20, 16'h0, 26'h0);
    send(2'd0, 6'd0, 5'd2, 5'd2, 5'd2, 5'd0, 6'h20, 16'h0, 26'h0);
    mon_en = 1'b0;
    rst_n = 1'b0;
    #2;
    n_checks++;
    if (out_valid !== 1'b0 || out_valid_n !== 1'b0 || in_ready !== 1'b0 || out_instr !== 32'h0 ||
        out_waddr !== 10'd0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: out_valid=%b in_ready=%b instr=%h waddr=%0d, required 0/0/0/0",
               out_valid, in_ready, out_instr, out_waddr);
    end
    q.delete();
    exp_addr = 0;
    err_pend = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    out_ready = 1'b1;
    send(2'd0, 6'd0, 5'd4, 5'd5, 5'd6, 5'd0, 6'h22, 16'h0, 26'h0);
    n_checks++;
    if (out_valid !== 1'b1 || out_instr !== 32'h00853022 || out_waddr !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_next: valid=%b instr=%h waddr=%0d, required 1 00853022 0", out_valid, out_instr, out_waddr);
    end
    wait_drain();
  endtask

  task automatic test_random();
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) send_random();
        rnd_done = 1'b1;
      end
      begin
        do begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end while (!rnd_done);
        out_ready = 1'b1;
      end
    join
    wait_drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_fmt = 2'd0; in_opcode = 6'd0; in_funct = 6'd0; in_rs = 5'd0; in_rt = 5'd0;
    in_rd = 5'd0; in_shamt = 5'd0; in_imm = 16'd0; in_addr = 26'd0;
    test_reset();
    test_r_type();
    test_back_to_back();
    test_stall();
    test_illegal();
    test_wrap();
    test_clear();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
